// File: rtl/io_in_conditioner.sv
// Input conditioner: per-channel synchroniser, debounce filter, and registered rise/fall pulses.
// Optional feature: define IO_IN_CONDITIONER_TOGGLE_EN to add push-button toggle latches on toggle_out.
module io_in_conditioner #(
  parameter int WIDTH           = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
`ifdef IO_IN_CONDITIONER_TOGGLE_EN
  output logic [WIDTH-1:0] toggle_out,
`endif
  output logic             any_change
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  assign sync = sync_q[SYNC_STAGES-1];

  // Each bit passes through its own shift chain before anything else looks at it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // any agreeing sample in between throws the partial count away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (sync[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else begin
          cnt_q[i]   <= '0;
          level_q[i] <= sync[i];
          rise_q[i]  <= sync[i];
          fall_q[i]  <= ~sync[i];
        end
      end
    end
  end

`ifdef IO_IN_CONDITIONER_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q;

  // Toggle lags the rise pulse by one edge so it is a clean registered update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ rise_q;
    end
  end

  assign toggle_out = toggle_q;
`endif

  assign level_out  = level_q;
  assign rise_out   = rise_q;
  assign fall_out   = fall_q;
  assign any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_io_in_conditioner.sv
// Self-checking bench for io_in_conditioner: expected level changes are queued when pins are driven
// and popped on the cycle the DUT should show them; all other cycles expect no pulse.
module tb_io_in_conditioner;

  localparam int W   = 7;
  localparam int LAT = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pin_in;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_out;
  logic [W-1:0] fall_out;
  logic         any_change;
`ifdef IO_IN_CONDITIONER_TOGGLE_EN
  logic [W-1:0] toggle_out;
`endif

  io_in_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .pin_in     (pin_in),
    .level_out  (level_out),
    .rise_out   (rise_out),
    .fall_out   (fall_out),
`ifdef IO_IN_CONDITIONER_TOGGLE_EN
    .toggle_out (toggle_out),
`endif
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t         sb[$];
  int           cyc;
  int           tests;
  int           failed;
  logic [W-1:0] exp_level;
  logic [W-1:0] exp_rise;
  logic [W-1:0] exp_fall;
  logic         exp_any;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int at, input logic [W-1:0] lvl, input logic [W-1:0] r, input logic [W-1:0] f);
    exp_t e;
    e.cyc = at; e.level = lvl; e.rise = r; e.fall = f;
    sb.push_back(e);
  endtask

  // Pop this cycle's expectation if one is due, else expect a quiet cycle.
  function automatic void sb_next();
    exp_t e;
    exp_rise = '0;
    exp_fall = '0;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      exp_level = e.level;
      exp_rise  = e.rise;
      exp_fall  = e.fall;
    end
    exp_any = |(exp_rise | exp_fall);
  endfunction

  task automatic hw_reset(input logic [W-1:0] pins);
    pin_in = pins;
    reset  = 1'b1;
    sb.delete();
    exp_level = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pin_in = 7'h7F;
    reset  = 1'b1;
    exp_level = '0;
    for (int t = 0; t < 3; t++) begin
      tick();
      tests++;
      if (level_out !== 7'h00 || rise_out !== 7'h00 || fall_out !== 7'h00 || any_change !== 1'b0) begin
        failed++;
        $display("[TB] FAIL reset_hold cyc=%0d level=%h rise=%h fall=%h any=%b required all 0",
                 cyc, level_out, rise_out, fall_out, any_change);
      end
    end
    reset = 1'b0;
    push(cyc + LAT, 7'h7F, 7'h7F, 7'h00);
    for (int t = 0; t < 24; t++) begin
      tick();
      sb_next();
      tests++;
      if (level_out !== exp_level || rise_out !== exp_rise || fall_out !== exp_fall || any_change !== exp_any) begin
        failed++;
        $display("[TB] FAIL reset_release cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h any=%b/%b (actual/required)",
                 cyc, level_out, exp_level, rise_out, exp_rise, fall_out, exp_fall, any_change, exp_any);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("[TB] FAIL reset_release_pending left=%0d required 0", sb.size());
    end
  endtask

  task automatic test_clean_edges();
    hw_reset(7'h00);
    for (int ph = 0; ph < 2; ph++) begin
      pin_in = (ph == 0) ? 7'h01 : 7'h00;
      if (ph == 0) push(cyc + LAT, 7'h01, 7'h01, 7'h00);
      else         push(cyc + LAT, 7'h00, 7'h00, 7'h01);
      for (int t = 0; t < 24; t++) begin
        tick();
        sb_next();
        tests++;
        if (level_out !== exp_level || rise_out !== exp_rise || fall_out !== exp_fall || any_change !== exp_any) begin
          failed++;
          $display("[TB] FAIL clean_edge ph=%0d cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h any=%b/%b (actual/required)",
                   ph, cyc, level_out, exp_level, rise_out, exp_rise, fall_out, exp_fall, any_change, exp_any);
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("[TB] FAIL clean_edge_pending left=%0d required 0", sb.size());
    end
  endtask

  task automatic test_glitch();
    pin_in = 7'h08;
    for (int t = 0; t < 50; t++) begin
      if (t == 10) pin_in = 7'h00;
      tick();
      sb_next();
      tests++;
      if (level_out !== 7'h00 || rise_out !== 7'h00 || fall_out !== 7'h00 || any_change !== 1'b0) begin
        failed++;
        $display("[TB] FAIL glitch cyc=%0d level=%h rise=%h fall=%h any=%b required all 0",
                 cyc, level_out, rise_out, fall_out, any_change);
      end
    end
  endtask

  task automatic test_bounce();
    int rises;
    int falls;
    rises = 0;
    falls = 0;
    for (int k = 0; k <= 10; k++) begin
      pin_in = (k % 2 == 0) ? 7'h04 : 7'h00;
      if (k == 10) push(cyc + LAT, 7'h04, 7'h04, 7'h00);
      for (int t = 0; t < ((k == 10) ? 24 : 3); t++) begin
        tick();
        sb_next();
        if (rise_out[2] === 1'b1) rises++;
        if (fall_out[2] === 1'b1) falls++;
        tests++;
        if (level_out !== exp_level || rise_out !== exp_rise || fall_out !== exp_fall || any_change !== exp_any) begin
          failed++;
          $display("[TB] FAIL bounce cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h any=%b/%b (actual/required)",
                   cyc, level_out, exp_level, rise_out, exp_rise, fall_out, exp_fall, any_change, exp_any);
        end
      end
    end
    tests++;
    if (rises != 1 || falls != 0 || sb.size() != 0) begin
      failed++;
      $display("[TB] FAIL bounce_count rises=%0d falls=%0d pending=%0d required 1 0 0", rises, falls, sb.size());
    end
  endtask

  task automatic test_simultaneous();
    int anys;
    hw_reset(7'h00);
    pin_in = 7'h02;
    push(cyc + LAT, 7'h02, 7'h02, 7'h00);
    for (int t = 0; t < 20; t++) begin
      tick();
      sb_next();
      tests++;
      if (level_out !== exp_level || rise_out !== exp_rise || fall_out !== exp_fall || any_change !== exp_any) begin
        failed++;
        $display("[TB] FAIL simul_setup cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h any=%b/%b (actual/required)",
                 cyc, level_out, exp_level, rise_out, exp_rise, fall_out, exp_fall, any_change, exp_any);
      end
    end
    anys = 0;
    pin_in = 7'h41;
    push(cyc + LAT, 7'h41, 7'h41, 7'h02);
    for (int t = 0; t < 24; t++) begin
      tick();
      sb_next();
      if (any_change === 1'b1) anys++;
      tests++;
      if (level_out !== exp_level || rise_out !== exp_rise || fall_out !== exp_fall || any_change !== exp_any) begin
        failed++;
        $display("[TB] FAIL simul cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h any=%b/%b (actual/required)",
                 cyc, level_out, exp_level, rise_out, exp_rise, fall_out, exp_fall, any_change, exp_any);
      end
    end
    tests++;
    if (anys != 1 || sb.size() != 0) begin
      failed++;
      $display("[TB] FAIL simul_count any_cycles=%0d pending=%0d required 1 0", anys, sb.size());
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] exp_tog;
    hw_reset(7'h00);
    exp_tog = '0;
    pin_in  = 7'h20;
    for (int t = 0; t < 12; t++) begin
      tick();
      sb_next();
      tests++;
      if (level_out !== exp_level || rise_out !== exp_rise || fall_out !== exp_fall || any_change !== exp_any) begin
        failed++;
        $display("[TB] FAIL midreset_pre cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h (actual/required)",
                 cyc, level_out, exp_level, rise_out, exp_rise, fall_out, exp_fall);
      end
    end
    hw_reset(7'h20);
    // Phases: held press after reset, release, second press.
    for (int ph = 0; ph < 3; ph++) begin
      pin_in = (ph == 1) ? 7'h00 : 7'h20;
      if (ph == 1) push(cyc + LAT, 7'h00, 7'h00, 7'h20);
      else         push(cyc + LAT, 7'h20, 7'h20, 7'h00);
      for (int t = 0; t < 22; t++) begin
        tick();
        sb_next();
        tests++;
        if (level_out !== exp_level || rise_out !== exp_rise || fall_out !== exp_fall || any_change !== exp_any) begin
          failed++;
          $display("[TB] FAIL midreset ph=%0d cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h any=%b/%b (actual/required)",
                   ph, cyc, level_out, exp_level, rise_out, exp_rise, fall_out, exp_fall, any_change, exp_any);
        end
`ifdef IO_IN_CONDITIONER_TOGGLE_EN
        tests++;
        if (toggle_out !== exp_tog) begin
          failed++;
          $display("[TB] FAIL toggle ph=%0d cyc=%0d toggle=%h required %h", ph, cyc, toggle_out, exp_tog);
        end
`endif
        exp_tog = exp_tog ^ exp_rise;
      end
    end
    tests++;
    if (sb.size() != 0 || exp_tog !== 7'h00) begin
      failed++;
      $display("[TB] FAIL midreset_pending left=%0d tog_model=%h required 0 00", sb.size(), exp_tog);
    end
  endtask

  initial begin
    cyc    = 0;
    tests  = 0;
    failed = 0;
    pin_in = '0;
    reset  = 1'b1;
    test_reset();
    test_clean_edges();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
